// File: rtl/mat_operand_feeder.sv
// Operand sequencer for a 3x3 dot-product stage. Loads A then B (row-major) from a
// serial element stream, then issues the nine (row of A, column of B) pairs in
// row-major result order with a ready/valid handshake on both sides.
module mat_operand_feeder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  axiiv,
   input  logic [WIDTH-1:0]      axiid,
   output logic                  axiir,
   output logic [2:0][WIDTH-1:0] row1,
   output logic [2:0][WIDTH-1:0] col2,
   output logic                  axiov,
   input  logic                  axior,
   output logic [1:0]            row_idx,
   output logic [1:0]            col_idx,
   output logic                  last
);

   typedef enum logic {StLoad, StIssue} state_e;

   state_e state_q, state_d;

   // Flat storage: entries 0..8 hold A row-major, 9..17 hold B row-major.
   logic [WIDTH-1:0]      mem_q [18];
   logic [WIDTH-1:0]      mem_v [18];
   logic [4:0]            cnt_q, cnt_d;
   logic [2:0][WIDTH-1:0] row1_q, row1_d, col2_q, col2_d;
   logic [2:0][WIDTH-1:0] sel_row, sel_col;
   logic [1:0]            ri_q, ri_d, ci_q, ci_d;
   logic [1:0]            nxt_i, nxt_j, pi, pj;
   logic                  axiov_q, axiov_d, last_q, last_d;
   logic                  accept, ld_first, xfer;

   assign accept   = axiiv && axiir;
   assign ld_first = accept && (cnt_q == 5'd17);
   assign xfer     = (state_q == StIssue) && axiov_q && axior;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StLoad;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad:  if (ld_first) state_d = StIssue;
         StIssue: if (xfer && last_q) state_d = StLoad;
         default: state_d = StLoad;
      endcase
   end

   // Decoded FSM output: input side is ready only while loading.
   always_comb begin
      axiir = (state_q == StLoad);
   end

   // Element storage; contents after reset are irrelevant but kept deterministic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < 18; n++) mem_q[n] <= '0;
      end else if (accept) begin
         mem_q[cnt_q] <= axiid;
      end
   end

   // Storage view with the element being written this cycle bypassed in.
   always_comb begin
      mem_v = mem_q;
      if (accept) mem_v[cnt_q] = axiid;
   end

   // Pair selection: (0,0) on load completion, else the row-major successor.
   always_comb begin
      if (ci_q == 2'd2) begin
         nxt_j = 2'd0;
         nxt_i = ri_q + 2'd1;
      end else begin
         nxt_j = ci_q + 2'd1;
         nxt_i = ri_q;
      end
      pi = ld_first ? 2'd0 : nxt_i;
      pj = ld_first ? 2'd0 : nxt_j;
      for (int k = 0; k < 3; k++) begin
         sel_row[k] = mem_v[5'(pi) * 5'd3 + 5'(k)];
         sel_col[k] = mem_v[5'd9 + 5'(k) * 5'd3 + 5'(pj)];
      end
   end

   // Next values for the byte counter and the registered issue outputs.
   always_comb begin
      cnt_d   = cnt_q;
      row1_d  = row1_q;
      col2_d  = col2_q;
      ri_d    = ri_q;
      ci_d    = ci_q;
      axiov_d = axiov_q;
      last_d  = last_q;
      if (accept) cnt_d = (cnt_q == 5'd17) ? 5'd0 : cnt_q + 5'd1;
      if (ld_first) begin
         row1_d  = sel_row;
         col2_d  = sel_col;
         ri_d    = 2'd0;
         ci_d    = 2'd0;
         axiov_d = 1'b1;
         last_d  = 1'b0;
      end else if (xfer) begin
         if (last_q) begin
            // row1/col2 intentionally keep the final pair.
            ri_d    = 2'd0;
            ci_d    = 2'd0;
            axiov_d = 1'b0;
            last_d  = 1'b0;
         end else begin
            row1_d = sel_row;
            col2_d = sel_col;
            ri_d   = nxt_i;
            ci_d   = nxt_j;
            last_d = (nxt_i == 2'd2) && (nxt_j == 2'd2);
         end
      end
   end

   // Counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         row1_q  <= '0;
         col2_q  <= '0;
         ri_q    <= '0;
         ci_q    <= '0;
         axiov_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         row1_q  <= row1_d;
         col2_q  <= col2_d;
         ri_q    <= ri_d;
         ci_q    <= ci_d;
         axiov_q <= axiov_d;
         last_q  <= last_d;
      end
   end

   assign row1    = row1_q;
   assign col2    = col2_q;
   assign row_idx = ri_q;
   assign col_idx = ci_q;
   assign axiov   = axiov_q;
   assign last    = last_q;

endmodule

// File: tb/tb_mat_operand_feeder.sv
// Directed bench for mat_operand_feeder: loads matrix pairs and checks every issued
// operand pair against a small reference built from the loaded matrices.
module tb_mat_operand_feeder;

   logic             clk = 1'b0;
   logic             rst;
   logic             axiiv;
   logic [7:0]       axiid;
   logic             axiir;
   logic [2:0][7:0]  row1;
   logic [2:0][7:0]  col2;
   logic             axiov;
   logic             axior;
   logic [1:0]       row_idx;
   logic [1:0]       col_idx;
   logic             last;

   int total = 0;
   int bad   = 0;

   logic [7:0] ma [9];
   logic [7:0] mb [9];

   mat_operand_feeder #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .axiiv   (axiiv),
      .axiid   (axiid),
      .axiir   (axiir),
      .row1    (row1),
      .col2    (col2),
      .axiov   (axiov),
      .axior   (axior),
      .row_idx (row_idx),
      .col_idx (col_idx),
      .last    (last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] exp_row(input int i);
      return {ma[3*i+2], ma[3*i+1], ma[3*i]};
   endfunction

   function automatic logic [23:0] exp_col(input int j);
      return {mb[6+j], mb[3+j], mb[j]};
   endfunction

   // Sends one element; called just after a falling edge, returns after the next one.
   task automatic send_byte(input logic [7:0] d);
      axiiv = 1'b1;
      axiid = d;
      chk("axiir_load", 32'(axiir), 32'd1);
      @(negedge clk);
      axiiv = 1'b0;
   endtask

   task automatic load(input bit gaps);
      for (int b = 0; b < 18; b++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            for (int n = 0; n < g; n++) begin
               chk("axiov_gap", 32'(axiov), 32'd0);
               @(negedge clk);
            end
         end
         send_byte(b < 9 ? ma[b] : mb[b-9]);
      end
   endtask

   // Checks nxfer transfers, stalling stall_n cycles before pair stall_at.
   task automatic issue(input int nxfer, input int stall_at, input int stall_n, input bit junk);
      for (int p = 0; p < nxfer; p++) begin
         if (p == stall_at) begin
            axior = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               @(negedge clk);
               chk("stall_axiov", 32'(axiov), 32'd1);
               chk("stall_row1", 32'(row1), 32'(exp_row(p / 3)));
               chk("stall_col2", 32'(col2), 32'(exp_col(p % 3)));
               chk("stall_idx", {30'd0, row_idx}, 32'(p / 3));
               chk("stall_cidx", {30'd0, col_idx}, 32'(p % 3));
            end
            axior = 1'b1;
         end
         chk("axiov", 32'(axiov), 32'd1);
         chk("axiir_issue", 32'(axiir), 32'd0);
         chk("row_idx", {30'd0, row_idx}, 32'(p / 3));
         chk("col_idx", {30'd0, col_idx}, 32'(p % 3));
         chk("row1", 32'(row1), 32'(exp_row(p / 3)));
         chk("col2", 32'(col2), 32'(exp_col(p % 3)));
         chk("last", 32'(last), 32'(p == 8));
         if (junk) begin
            axiiv = 1'b1;
            axiid = 8'($urandom);
         end
         @(negedge clk);
         axiiv = 1'b0;
      end
      if (nxfer == 9) begin
         chk("post_axiov", 32'(axiov), 32'd0);
         chk("post_axiir", 32'(axiir), 32'd1);
         chk("post_last", 32'(last), 32'd0);
         chk("post_idx", {28'd0, row_idx, col_idx}, 32'd0);
         chk("post_row1_hold", 32'(row1), 32'(exp_row(2)));
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_axiov"}, 32'(axiov), 32'd0);
      chk({tag, "_axiir"}, 32'(axiir), 32'd1);
      chk({tag, "_row1"}, 32'(row1), 32'd0);
      chk({tag, "_col2"}, 32'(col2), 32'd0);
      chk({tag, "_last"}, 32'(last), 32'd0);
      chk({tag, "_idx"}, {28'd0, row_idx, col_idx}, 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      axiiv = 1'b0;
      axiid = '0;
      axior = 1'b1;
      #1;
      chk_reset_state("reset");
      @(negedge clk);
      rst = 1'b0;

      // All-ones matrices, no stalls.
      for (int n = 0; n < 9; n++) begin
         ma[n] = 8'h01;
         mb[n] = 8'h01;
      end
      load(1'b0);
      issue(9, -1, 0, 1'b0);

      // A = 1..9, B = identity; back-to-back with the previous issue.
      for (int n = 0; n < 9; n++) begin
         ma[n] = 8'(n + 1);
         mb[n] = (n % 4 == 0) ? 8'h01 : 8'h00;
      end
      load(1'b0);
      issue(9, -1, 0, 1'b0);

      // Backpressure on pair (1,0).
      for (int n = 0; n < 9; n++) begin
         ma[n] = 8'(8'h10 + n);
         mb[n] = 8'(8'hA0 + 3 * n);
      end
      load(1'b0);
      issue(9, 3, 3, 1'b0);

      // Gapped load, junk driven during issue.
      load(1'b1);
      issue(9, -1, 0, 1'b1);
      // The following load must start at A[0][0] despite the junk.
      for (int n = 0; n < 9; n++) begin
         ma[n] = 8'(8'h40 + 7 * n);
         mb[n] = 8'(8'hF0 - 5 * n);
      end
      load(1'b0);
      issue(9, -1, 0, 1'b0);

      // Reset after 10 accepted bytes.
      for (int b = 0; b < 10; b++) send_byte(8'h55);
      rst = 1'b1;
      #1;
      chk_reset_state("rst_load");
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 9; n++) begin
         ma[n] = 8'(8'h21 + n);
         mb[n] = 8'(8'h61 + 2 * n);
      end
      load(1'b0);
      issue(9, -1, 0, 1'b0);

      // Reset after five transfers of an issue.
      load(1'b0);
      issue(5, -1, 0, 1'b0);
      rst = 1'b1;
      #1;
      chk_reset_state("rst_issue");
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 9; n++) begin
         ma[n] = 8'(8'h80 + n);
         mb[n] = 8'(8'h08 * n + 1);
      end
      load(1'b1);
      issue(9, -1, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
